// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vid_pkg
//  Purpose  : Shared constants and frame-state encoding for the video blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package vid_pkg;

    localparam int unsigned c_VID_DATA_WIDTH = 24;
    localparam int unsigned c_WIN_SIZE       = 3;
    localparam int unsigned c_WIN_TAPS       = c_WIN_SIZE * c_WIN_SIZE;

    typedef logic [1:0] vid_state_t;

    localparam vid_state_t c_ST_IDLE   = 2'd0;
    localparam vid_state_t c_ST_FILL   = 2'd1;
    localparam vid_state_t c_ST_ACTIVE = 2'd2;

endpackage : vid_pkg
`default_nettype wire

// File: rtl/vid_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : vid_line_buffer
//  Purpose  : Simple dual-port line RAM with a registered read port.
//  Revision : 1.0 - initial release
// ============================================================================
module vid_line_buffer
    import vid_pkg::*;
#(
    parameter int DATA_WIDTH = c_VID_DATA_WIDTH,
    parameter int MAX_WIDTH  = 2048,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:MAX_WIDTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Contents are intentionally not reset; the read returns the old word on
    // a same-address write.
    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[i_rd_addr];
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : vid_line_buffer
`default_nettype wire

// File: rtl/vid_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : vid_window_3x3
//  Purpose  : 3x3 sliding pixel window over a vid_io stream, two line buffers.
//  Revision : 1.0 - initial release
// ============================================================================
module vid_window_3x3
    import vid_pkg::*;
#(
    parameter int DATA_WIDTH = c_VID_DATA_WIDTH,
    parameter int MAX_WIDTH  = 2048,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            i_vid_data,
    input  logic                             i_vid_hsync,
    input  logic                             i_vid_vsync,
    input  logic                             i_vid_VDE,
    output logic [c_WIN_TAPS*DATA_WIDTH-1:0] o_win,
    output logic                             o_win_valid,
    output logic                             o_vid_hsync,
    output logic                             o_vid_vsync,
    output logic                             o_vid_VDE,
    output logic                             o_ovf
);

    localparam logic [ADDR_WIDTH-1:0] c_COL_MAX         = ADDR_WIDTH'(MAX_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_COL_FIRST_VALID = ADDR_WIDTH'(c_WIN_SIZE - 1);
    localparam logic [1:0]            c_ROW_FULL        = 2'(c_WIN_SIZE - 1);

    logic [ADDR_WIDTH-1:0] r_col;
    logic [ADDR_WIDTH-1:0] r_col_d1;
    logic                  r_col_sat;
    logic [1:0]            r_row;
    vid_state_t            r_state;
    logic                  r_vsync_prev;
    logic                  r_vde_prev;
    logic [1:0]            r_vde_pipe;
    logic [1:0]            r_hs_pipe;
    logic [1:0]            r_vs_pipe;
    logic [DATA_WIDTH-1:0] r_pix_d1;
    logic                  r_we0_d1;
    logic                  r_ovf;
    logic                  r_win_valid;
    logic [DATA_WIDTH-1:0] r_win [0:c_WIN_TAPS-1];

    logic [DATA_WIDTH-1:0] w_lb0_rd;
    logic [DATA_WIDTH-1:0] w_lb1_rd;
    logic                  w_vsync_rise;
    logic                  w_vde_fall;
    logic                  w_we0;

    assign w_vsync_rise = i_vid_vsync & ~r_vsync_prev;
    assign w_vde_fall   = ~i_vid_VDE & r_vde_prev;
    // r_col_sat means the last column slot is already used by this line.
    assign w_we0        = i_vid_VDE & ~r_col_sat;

    // Column / row counters, overflow flag and frame FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_col_sat    <= 1'b0;
            r_row        <= '0;
            r_state      <= c_ST_IDLE;
            r_vsync_prev <= 1'b0;
            r_vde_prev   <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_vsync_prev <= i_vid_vsync;
            // A line cut short by vsync must not count as a completed line.
            r_vde_prev   <= i_vid_VDE & ~w_vsync_rise;

            if (w_vsync_rise || !i_vid_VDE) begin
                r_col     <= '0;
                r_col_sat <= 1'b0;
            end else if (r_col == c_COL_MAX) begin
                r_col_sat <= 1'b1;
            end else begin
                r_col <= r_col + ADDR_WIDTH'(1);
            end

            if (w_vsync_rise) begin
                r_row <= '0;
            end else if (w_vde_fall && (r_row != c_ROW_FULL)) begin
                r_row <= r_row + 2'd1;
            end

            if (w_vsync_rise) begin
                r_ovf <= 1'b0;
            end else if (i_vid_VDE && r_col_sat) begin
                r_ovf <= 1'b1;
            end

            if (w_vsync_rise) begin
                r_state <= c_ST_FILL;
            end else begin
                case (r_state)
                    c_ST_IDLE:   ;
                    c_ST_FILL:   if (r_row == c_ROW_FULL) r_state <= c_ST_ACTIVE;
                    c_ST_ACTIVE: ;
                    default:     r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // Delay pipes and window shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vde_pipe  <= '0;
            r_hs_pipe   <= '0;
            r_vs_pipe   <= '0;
            r_pix_d1    <= '0;
            r_col_d1    <= '0;
            r_we0_d1    <= 1'b0;
            r_win_valid <= 1'b0;
            for (int k = 0; k < int'(c_WIN_TAPS); k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_vde_pipe  <= {r_vde_pipe[0], i_vid_VDE};
            r_hs_pipe   <= {r_hs_pipe[0], i_vid_hsync};
            r_vs_pipe   <= {r_vs_pipe[0], i_vid_vsync};
            r_pix_d1    <= i_vid_data;
            r_col_d1    <= r_col;
            r_we0_d1    <= w_we0;
            r_win_valid <= (r_state == c_ST_ACTIVE) && r_vde_pipe[0] &&
                           (r_col_d1 >= c_COL_FIRST_VALID);
            if (r_vde_pipe[0]) begin
                for (int l = 0; l < int'(c_WIN_SIZE); l++) begin
                    r_win[l*c_WIN_SIZE]     <= r_win[l*c_WIN_SIZE + 1];
                    r_win[l*c_WIN_SIZE + 1] <= r_win[l*c_WIN_SIZE + 2];
                end
                r_win[c_WIN_SIZE - 1]     <= w_lb1_rd;
                r_win[2*c_WIN_SIZE - 1]   <= w_lb0_rd;
                r_win[c_WIN_TAPS - 1]     <= r_pix_d1;
            end
        end
    end

    vid_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_WIDTH  (MAX_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lb0 (
        .clk       (clk),
        .i_wr_en   (w_we0),
        .i_wr_addr (r_col),
        .i_wr_data (i_vid_data),
        .i_rd_addr (r_col),
        .o_rd_data (w_lb0_rd)
    );

    // LB1 takes LB0's old word one cycle later, once the registered read lands.
    vid_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_WIDTH  (MAX_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lb1 (
        .clk       (clk),
        .i_wr_en   (r_we0_d1),
        .i_wr_addr (r_col_d1),
        .i_wr_data (w_lb0_rd),
        .i_rd_addr (r_col),
        .o_rd_data (w_lb1_rd)
    );

    generate
        for (genvar k = 0; k < int'(c_WIN_TAPS); k++) begin : g_pack
            assign o_win[(int'(c_WIN_TAPS) - 1 - k)*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
        end
    endgenerate

    assign o_win_valid = r_win_valid;
    assign o_vid_hsync = r_hs_pipe[1];
    assign o_vid_vsync = r_vs_pipe[1];
    assign o_vid_VDE   = r_vde_pipe[1];
    assign o_ovf       = r_ovf;

endmodule : vid_window_3x3
`default_nettype wire

// File: tb/tb_vid_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vid_window_3x3
//  Purpose  : Directed self-checking bench for vid_window_3x3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vid_window_3x3;
    import vid_pkg::*;

    localparam int c_DW   = 24;
    localparam int c_WW   = 9 * c_DW;
    localparam int c_HIST = 16384;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [c_DW-1:0] r_data = '0;
    logic            r_hs = 1'b0;
    logic            r_vs = 1'b0;
    logic            r_vde = 1'b0;
    logic [c_WW-1:0] w_win;
    logic            w_valid;
    logic            w_hs;
    logic            w_vs;
    logic            w_vde;
    logic            w_ovf;

    always #5 clk = ~clk;

    vid_window_3x3 dut (
        .clk         (clk),
        .rst         (rst),
        .i_vid_data  (r_data),
        .i_vid_hsync (r_hs),
        .i_vid_vsync (r_vs),
        .i_vid_VDE   (r_vde),
        .o_win       (w_win),
        .o_win_valid (w_valid),
        .o_vid_hsync (w_hs),
        .o_vid_vsync (w_vs),
        .o_vid_VDE   (w_vde),
        .o_ovf       (w_ovf)
    );

    int total  = 0;
    int bad    = 0;
    int n      = 0;
    int vcount = 0;
    bit chk_win = 1'b1;
    bit fr_ok   = 1'b0;

    logic            h_vde  [c_HIST];
    logic            h_hs   [c_HIST];
    logic            h_vs   [c_HIST];
    logic            h_ev   [c_HIST];
    logic            h_chkw [c_HIST];
    logic [c_WW-1:0] h_win  [c_HIST];

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [c_DW-1:0] pix(input int r, input int c);
        return c_DW'((r << 8) | c);
    endfunction

    function automatic logic [c_WW-1:0] exp_win(input int r, input int c);
        logic [c_WW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(8 - (i*3 + j))*c_DW +: c_DW] = pix(r - 2 + i, c - 2 + j);
        return w;
    endfunction

    // One clock: drive inputs, record expectations, check what left the pipe.
    task automatic tick(input logic vde, input logic hs, input logic vs, input logic rs,
                        input logic [c_DW-1:0] d, input logic ev, input logic [c_WW-1:0] ew);
        r_vde = vde; r_hs = hs; r_vs = vs; rst = rs; r_data = d;
        h_vde[n]  = vde & ~rs;
        h_hs[n]   = hs & ~rs;
        h_vs[n]   = vs & ~rs;
        h_ev[n]   = ev & ~rs;
        h_win[n]  = rs ? '0 : ew;
        h_chkw[n] = ev | rs;
        if (rs && n >= 1) begin
            h_vde[n-1] = 1'b0; h_hs[n-1] = 1'b0; h_vs[n-1] = 1'b0;
            h_ev[n-1] = 1'b0; h_win[n-1] = '0; h_chkw[n-1] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (w_valid) vcount++;
        if (n >= 1) begin
            check("vde_dly", w_vde, h_vde[n-1]);
            check("hsync_dly", w_hs, h_hs[n-1]);
            check("vsync_dly", w_vs, h_vs[n-1]);
            if (chk_win) begin
                check("win_valid", w_valid, h_ev[n-1]);
                if (h_chkw[n-1]) check("win", w_win, h_win[n-1]);
            end
        end
        n++;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic hblank();
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic vblank();
        tick(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        fr_ok = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(2);
    endtask

    // Sends one active line; vs_col/rst_col (if >= 0) inject an event there.
    task automatic send_line(input int r, input int w, input int vs_col, input int rst_col);
        logic vs;
        logic rs;
        logic ev;
        for (int c = 0; c < w; c++) begin
            vs = (c == vs_col);
            rs = (c == rst_col);
            ev = fr_ok && (r >= 2) && (c >= 2) && !vs && !rs;
            tick(1'b1, 1'b0, vs, rs, pix(r, c), ev, exp_win(r, c));
            if (rs) begin
                fr_ok = 1'b0;
                check("rst_state", dut.r_state, c_ST_IDLE);
                check("rst_ovf", w_ovf, 1'b0);
            end
            if (vs) begin
                fr_ok = 1'b1;
                check("vs_row", dut.r_row, 2'd0);
                check("vs_col", dut.r_col, 11'd0);
                check("vs_state", dut.r_state, c_ST_FILL);
                return;
            end
        end
        hblank();
    endtask

    task automatic send_rows(input int first, input int last, input int w);
        for (int r = first; r <= last; r++) send_line(r, w, -1, -1);
    endtask

    initial begin
        // Reset
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
        idle(2);
        check("reset_ovf", w_ovf, 1'b0);
        check("reset_state", dut.r_state, c_ST_IDLE);

        // Clean 8x4 frame: 12 valid windows
        vblank();
        vcount = 0;
        send_rows(0, 3, 8);
        check("frame_valid_count", vcount, 12);

        // Random timing: output syncs are the inputs delayed by 2
        chk_win = 1'b0;
        for (int i = 0; i < 1000; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b0, c_DW'($urandom), 1'b0, '0);
        idle(3);
        chk_win = 1'b1;

        // Overflow: a full-width line is fine, a 2050-pixel line sets the flag
        vblank();
        for (int c = 0; c < 2048; c++) tick(1'b1, 1'b0, 1'b0, 1'b0, pix(0, c), 1'b0, '0);
        hblank();
        check("ovf_full_line", w_ovf, 1'b0);
        for (int c = 0; c < 2050; c++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, pix(1, c), 1'b0, '0);
            if (c == 2047) check("ovf_before_sat", w_ovf, 1'b0);
            if (c == 2048) check("ovf_set", w_ovf, 1'b1);
        end
        hblank();
        check("ovf_hold_blank", w_ovf, 1'b1);
        send_line(2, 8, -1, -1);
        check("ovf_hold_line", w_ovf, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        check("ovf_clear_vsync", w_ovf, 1'b0);
        fr_ok = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(2);

        // Mid-line vsync at row 3 col 5 restarts the frame
        vblank();
        send_rows(0, 2, 8);
        send_line(3, 8, 5, -1);
        vcount = 0;
        tick(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(3);
        send_rows(0, 1, 8);
        check("vs_no_valid_rows01", vcount, 0);
        send_rows(2, 3, 8);
        check("vs_new_frame_count", vcount, 12);

        // One-cycle reset during row 3; windows return only after vsync + 2 lines
        vblank();
        send_rows(0, 2, 8);
        send_line(3, 8, -1, 3);
        vcount = 0;
        send_rows(4, 5, 8);
        check("rst_no_valid_before_vsync", vcount, 0);
        vblank();
        send_rows(0, 3, 8);
        check("rst_resume_count", vcount, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vid_window_3x3
`default_nettype wire
